noc_port_merger: RTL and testbench
==================================

Name: noc_port_merger

Overview:
- Parametrised successor to the single-port NoC receive connector.
- Accepts N_PORTS independent flit streams, each with the valid/ready/VCready/header/tail interface.
- Buffers each stream in a per-port FIFO and merges them onto one output link.
- Uses wormhole, packet-atomic round-robin arbitration. Sits between local injectors and a router input port.

Parameters:
- N_PORTS, 4, number of input channels (2..8).
- DATA_W, `Noc_Data_Width, flit payload width.
- DEPTH, 4, per-port FIFO depth in flits (power of 2, >=2).
- VC_THRESH, 2, minimum free slots for in_vcready to assert (1..DEPTH).

Ports:
- noc_clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  N_PORTS  per-port flit valid.
- in_ready  out  N_PORTS  per-port FIFO not full.
- in_flit  in  N_PORTS*DATA_W  port p occupies bits [p*DATA_W +: DATA_W].
- in_vcready  out  N_PORTS  registered; free slots >= VC_THRESH.
- in_is_header  in  N_PORTS  flit is packet header.
- in_is_tail  in  N_PORTS  flit is packet tail.
- out_valid  out  1  output flit valid.
- out_ready  in  1  downstream accepts.
- out_flit  out  DATA_W  output flit.
- out_is_header  out  1  header marker.
- out_is_tail  out  1  tail marker.
- out_src  out  clog2(N_PORTS)  index of granted port.
- proto_err  out  N_PORTS  sticky error flags (optional feature only; tied 0 otherwise).

Behaviour:
- Clocking/reset: single clock noc_clk; reset rst_n is asynchronous, active-low. Reset clears FIFO pointers/counts, FSM, grant, rr pointer, in_vcready register.
- Reset output values: in_ready=all 1, in_vcready=all 1, out_valid=0, out_src=0, out_flit/markers=0, proto_err=0.
- Push: FIFO p stores {header, tail, flit} when in_valid[p] && in_ready[p]. in_ready[p] = !full[p], derived from the registered count.
- Full FIFO with a pop in the same cycle still refuses the push; in_ready is not a function of out_ready.
- A flit written at edge t is at the FIFO head after t; no same-cycle bypass.
- in_vcready[p] is registered each cycle from the next-state count: (DEPTH - count_next) >= VC_THRESH.
- FSM state IDLE:
  - Eligible ports have non-empty FIFO with header bit set at head.
  - Pick the first eligible port at or after rr_ptr (wrapping modulo N_PORTS), register it as grant, go to LOCK.
  - out_valid=0 in IDLE.
- FSM state LOCK:
  - out_valid = !empty[grant]; out_flit/markers = head of FIFO[grant]; out_src=grant.
  - Pop on out_valid && out_ready.
  - Pop of a tail flit → IDLE, rr_ptr = grant+1 (wrap).
  - Other ports are never interleaved mid-packet. An empty granted FIFO mid-packet holds LOCK with out_valid=0.
- Single-flit packet (header and tail both set): LOCK for exactly one transfer.
- Latency: header pushed at edge t on an idle merger → grant at edge t+1 → out_valid from t+1. Minimum 2 cycles from in_valid to out_valid.
- Throughput: back-to-back packets from the same port incur 1 idle cycle (LOCK→IDLE→LOCK).
- out_valid, once asserted, holds with stable data until accepted.
- Non-header flit at an idle-state head:
  - Without the optional feature, it is treated as eligible (header implied).

Optional Feature:
- Macro: NOC_MERGER_PROTO_CHECK_EN.
- Enabled: in IDLE, a non-header head flit is popped and discarded (not forwarded), and proto_err[p] sets and stays set until reset.
- Also enabled: in LOCK, a pushed header on the granted port before the tail was seen sets proto_err[grant]; that header is still forwarded.
- Disabled: no check logic; proto_err tied 0; implied-header rule applies.

Decomposition:
- Noc_parameters.v holds Noc_Data_Width, the FSM state encodings (IDLE=0, LOCK=1), and the packed FIFO entry width (DATA_W+2).
- One natural sub-module, noc_merger_fifo: a synchronous FIFO instantiated N_PORTS times via generate, exposing count, full, empty and head.

Test Plan:
- Single port 0, 3-flit packet (0xA1 H, 0xA2, 0xA3 T), out_ready=1 → out_flit A1,A2,A3 on consecutive cycles, first out_valid 2 cycles after push, out_src=0.
- Ports 1 and 2 each push a 2-flit packet the same cycle, rr_ptr=0 → port 1 packet whole, 1 idle cycle, then port 2 whole; no interleaving.
- Port 0 pushes 4 flits with out_ready=0, DEPTH=4 → in_ready[0]=0 after 4th push; in_vcready[0] deasserts after the 3rd push (VC_THRESH=2); releasing out_ready restores both.
- All 4 ports send single-flit packets continuously → out_src sequence 0,1,2,3,0 (fair round-robin).
- Reset asserted mid-packet (after 1 of 3 flits output) → out_valid=0 and in_ready=all 1 immediately; the new header afterwards is forwarded normally.
- With NOC_MERGER_PROTO_CHECK_EN, port 3 pushes non-header 0x55 while idle → 0x55 never appears on out_flit, proto_err[3]=1 sticky.

Source files
------------

// File: rtl/noc_port_merger_pkg.sv
// Shared definitions for the NoC port merger: default flit width, FSM encoding
// and the packed FIFO entry width ({header, tail, flit}).
package noc_port_merger_pkg;

  localparam int NOC_DATA_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  function automatic int entry_width(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/noc_merger_fifo.sv
// Per-port synchronous FIFO; the head entry is visible combinationally, and a
// write only appears at the head after the clock edge that stores it.
module noc_merger_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/noc_port_merger.sv
// Merges N_PORTS buffered flit streams onto one link with packet-atomic
// round-robin arbitration. Optional protocol checking: NOC_MERGER_PROTO_CHECK_EN.
module noc_port_merger
  import noc_port_merger_pkg::*;
#(
  parameter int N_PORTS   = 4,
  parameter int DATA_W    = NOC_DATA_WIDTH,
  parameter int DEPTH     = 4,
  parameter int VC_THRESH = 2,
  localparam int SRC_W = $clog2(N_PORTS),
  localparam int EW    = DATA_W + 2,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                      noc_clk,
  input  logic                      rst_n,
  input  logic [N_PORTS-1:0]        in_valid,
  output logic [N_PORTS-1:0]        in_ready,
  input  logic [N_PORTS*DATA_W-1:0] in_flit,
  output logic [N_PORTS-1:0]        in_vcready,
  input  logic [N_PORTS-1:0]        in_is_header,
  input  logic [N_PORTS-1:0]        in_is_tail,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_flit,
  output logic                      out_is_header,
  output logic                      out_is_tail,
  output logic [SRC_W-1:0]          out_src,
  output logic [N_PORTS-1:0]        proto_err
);

  logic [N_PORTS-1:0] push;
  logic [N_PORTS-1:0] pop;
  logic [N_PORTS-1:0] full;
  logic [N_PORTS-1:0] empty;
  logic [N_PORTS-1:0] eligible;
  logic [N_PORTS-1:0] head_tail;
  logic [EW-1:0]      head [N_PORTS];
  logic [CW-1:0]      count [N_PORTS];
  logic [CW-1:0]      count_next [N_PORTS];
  logic [N_PORTS-1:0] vcready_p1;

  state_t           state;
  state_t           state_next;
  logic [SRC_W-1:0] grant;
  logic [SRC_W-1:0] grant_next;
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] rr_next;
  logic [SRC_W-1:0] sel;
  logic             found;
  logic             lock_valid;
  int               idx;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    noc_merger_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (noc_clk),
      .rst_n (rst_n),
      .push  (push[p]),
      .pop   (pop[p]),
      .wdata ({in_is_header[p], in_is_tail[p], in_flit[p*DATA_W +: DATA_W]}),
      .head  (head[p]),
      .count (count[p]),
      .full  (full[p]),
      .empty (empty[p])
    );
    assign push[p]      = in_valid[p] && !full[p];
    assign head_tail[p] = head[p][EW-2];
  end

  assign in_ready = ~full;

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      count_next[p] = count[p] + CW'(push[p]) - CW'(pop[p]);
    end
  end

  // vcready_p1: credit view registered from the next-state occupancy
  always_ff @(posedge noc_clk or negedge rst_n) begin
    if (!rst_n) begin
      vcready_p1 <= '1;
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        vcready_p1[p] <= (CW'(DEPTH) - count_next[p]) >= CW'(VC_THRESH);
      end
    end
  end

  assign in_vcready = vcready_p1;

`ifdef NOC_MERGER_PROTO_CHECK_EN
  logic [N_PORTS-1:0] discard;
  logic [N_PORTS-1:0] hdr_err;
  logic [N_PORTS-1:0] pkt_open;
  logic [N_PORTS-1:0] err_flags;

  always_comb begin
    eligible = '0;
    discard  = '0;
    hdr_err  = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      eligible[p] = !empty[p] && head[p][EW-1];
      discard[p]  = (state == IDLE) && !empty[p] && !head[p][EW-1];
    end
    // A header arriving on the locked port while its packet is still open
    if (state == LOCK && push[grant] && in_is_header[grant] && pkt_open[grant]) begin
      hdr_err[grant] = 1'b1;
    end
  end

  always_ff @(posedge noc_clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_open  <= '0;
      err_flags <= '0;
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (push[p]) begin
          if (in_is_tail[p]) begin
            pkt_open[p] <= 1'b0;
          end else if (in_is_header[p]) begin
            pkt_open[p] <= 1'b1;
          end
        end
      end
      err_flags <= err_flags | discard | hdr_err;
    end
  end

  assign proto_err = err_flags;
`else
  assign eligible  = ~empty;
  assign proto_err = '0;
`endif

  always_ff @(posedge noc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_next;
      grant  <= grant_next;
      rr_ptr <= rr_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    rr_next    = rr_ptr;
    pop        = '0;
    lock_valid = 1'b0;
    found      = 1'b0;
    idx        = 0;
    sel        = '0;
    case (state)
      IDLE: begin
        for (int i = 0; i < N_PORTS; i++) begin
          idx = int'(rr_ptr) + i;
          if (idx >= N_PORTS) begin
            idx = idx - N_PORTS;
          end
          sel = SRC_W'(idx);
          if (!found && eligible[sel]) begin
            found      = 1'b1;
            grant_next = sel;
            state_next = LOCK;
          end
        end
      end
      LOCK: begin
        lock_valid = !empty[grant];
        if (lock_valid && out_ready) begin
          pop[grant] = 1'b1;
          if (head_tail[grant]) begin
            state_next = IDLE;
            rr_next    = (grant == SRC_W'(N_PORTS - 1)) ? '0 : grant + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
`ifdef NOC_MERGER_PROTO_CHECK_EN
    pop = pop | discard;
`endif
  end

  assign out_valid = lock_valid;
  assign out_src   = grant;
  assign {out_is_header, out_is_tail, out_flit} = (state == LOCK) ? head[grant] : '0;

endmodule

// File: tb/tb_noc_port_merger.sv
// Self-checking bench for noc_port_merger: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_noc_port_merger;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int VCT   = 2;

  logic              noc_clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_ready;
  logic [N*DW-1:0]   in_flit;
  logic [N-1:0]      in_vcready;
  logic [N-1:0]      in_is_header;
  logic [N-1:0]      in_is_tail;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_flit;
  logic              out_is_header;
  logic              out_is_tail;
  logic [1:0]        out_src;
  logic [N-1:0]      proto_err;

  int tests  = 0;
  int errors = 0;

  always #5 noc_clk = ~noc_clk;

  noc_port_merger #(
    .N_PORTS   (N),
    .DATA_W    (DW),
    .DEPTH     (DEPTH),
    .VC_THRESH (VCT)
  ) dut (
    .noc_clk       (noc_clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_flit       (in_flit),
    .in_vcready    (in_vcready),
    .in_is_header  (in_is_header),
    .in_is_tail    (in_is_tail),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_flit      (out_flit),
    .out_is_header (out_is_header),
    .out_is_tail   (out_is_tail),
    .out_src       (out_src),
    .proto_err     (proto_err)
  );

  typedef struct {
    int         port;
    logic [7:0] data;
    logic       hdr;
    logic       tail;
    logic       exp_valid;
    logic [1:0] exp_src;
    logic [7:0] exp_flit;
    logic       exp_hdr;
  } vec_t;

  typedef struct packed {
    logic       h;
    logic       t;
    logic [7:0] d;
  } ent_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge noc_clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic v, input logic [7:0] d,
                          input logic h, input logic t);
    in_valid[p]          = v;
    in_flit[p*DW +: DW]  = d;
    in_is_header[p]      = h;
    in_is_tail[p]        = t;
  endtask

  task automatic do_reset();
    in_valid     = '0;
    in_flit      = '0;
    in_is_header = '0;
    in_is_tail   = '0;
    out_ready    = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(posedge noc_clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  vec_t vt [6];
  ent_t q [N][$];
  ent_t pend [N];
  bit   pend_ok [N];
  int   rem [N];
  bit   first;
  int   srcs [$];
  logic [7:0] exp2_flit [6];
  logic       exp2_vld  [6];
  logic [1:0] exp2_src  [6];

  initial begin
    // ---------------- reset state ----------------
    do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 4'hF);
    chk("rst_vcready", in_vcready, 4'hF);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_out_flit", {out_is_header, out_is_tail, out_flit}, 0);
    chk("rst_proto_err", proto_err, 0);
    do_reset();

    // ---------------- vector table ----------------
    vt[0] = '{0, 8'h11, 1'b1, 1'b1, 1'b1, 2'd0, 8'h11, 1'b1};
    vt[1] = '{2, 8'h22, 1'b1, 1'b1, 1'b1, 2'd2, 8'h22, 1'b1};
    vt[2] = '{3, 8'h33, 1'b1, 1'b1, 1'b1, 2'd3, 8'h33, 1'b1};
    vt[4] = '{1, 8'h55, 1'b1, 1'b1, 1'b1, 2'd1, 8'h55, 1'b1};
`ifdef NOC_MERGER_PROTO_CHECK_EN
    vt[3] = '{1, 8'h44, 1'b0, 1'b1, 1'b0, 2'd1, 8'h00, 1'b0};
    vt[5] = '{3, 8'h66, 1'b0, 1'b1, 1'b0, 2'd3, 8'h00, 1'b0};
`else
    vt[3] = '{1, 8'h44, 1'b0, 1'b1, 1'b1, 2'd1, 8'h44, 1'b0};
    vt[5] = '{3, 8'h66, 1'b0, 1'b1, 1'b1, 2'd3, 8'h66, 1'b0};
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_port(vt[i].port, 1'b1, vt[i].data, vt[i].hdr, vt[i].tail);
      tick();
      set_port(vt[i].port, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("tbl_idle_valid", out_valid, 0);
      tick();
      chk("tbl_valid", out_valid, vt[i].exp_valid);
      if (vt[i].exp_valid) begin
        chk("tbl_src", out_src, vt[i].exp_src);
        chk("tbl_flit", out_flit, vt[i].exp_flit);
        chk("tbl_hdr", out_is_header, vt[i].exp_hdr);
        chk("tbl_tail", out_is_tail, 1);
      end
`ifdef NOC_MERGER_PROTO_CHECK_EN
      else begin
        chk("tbl_proto_err", proto_err[vt[i].port], 1);
      end
`endif
      tick();
      tick();
    end

    // ---------------- 3-flit packet, latency ----------------
    do_reset();
    out_ready = 1'b1;
    set_port(0, 1'b1, 8'hA1, 1'b1, 1'b0);
    tick();
    chk("lat_idle", out_valid, 0);
    set_port(0, 1'b1, 8'hA2, 1'b0, 1'b0);
    tick();
    chk("lat_valid", out_valid, 1);
    chk("lat_a1", {out_is_header, out_is_tail, out_flit}, {2'b10, 8'hA1});
    chk("lat_src", out_src, 0);
    set_port(0, 1'b1, 8'hA3, 1'b0, 1'b1);
    tick();
    chk("lat_a2", {out_valid, out_is_header, out_is_tail, out_flit}, {3'b100, 8'hA2});
    set_port(0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("lat_a3", {out_valid, out_is_header, out_is_tail, out_flit}, {3'b101, 8'hA3});
    tick();
    chk("lat_done", out_valid, 0);

    // ---------------- two ports, same cycle ----------------
    do_reset();
    out_ready = 1'b1;
    set_port(1, 1'b1, 8'hB1, 1'b1, 1'b0);
    set_port(2, 1'b1, 8'hC1, 1'b1, 1'b0);
    tick();
    chk("two_idle", out_valid, 0);
    set_port(1, 1'b1, 8'hB2, 1'b0, 1'b1);
    set_port(2, 1'b1, 8'hC2, 1'b0, 1'b1);
    exp2_vld  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    exp2_flit = '{8'hB1, 8'hB2, 8'h00, 8'hC1, 8'hC2, 8'h00};
    exp2_src  = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
    for (int i = 0; i < 6; i++) begin
      tick();
      set_port(1, 1'b0, 8'h00, 1'b0, 1'b0);
      set_port(2, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("two_valid", out_valid, exp2_vld[i]);
      if (exp2_vld[i]) begin
        chk("two_flit", out_flit, exp2_flit[i]);
        chk("two_src", out_src, exp2_src[i]);
      end
    end

    // ---------------- fill / backpressure ----------------
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_port(0, 1'b1, 8'hD0 + 8'(k), k == 0, k == 3);
      tick();
      chk("fill_ready", in_ready[0], k < 3);
      chk("fill_vcready", in_vcready[0], k < 2);
    end
    chk("fill_hold", {out_valid, out_flit}, {1'b1, 8'hD0});
    set_port(0, 1'b1, 8'hDF, 1'b1, 1'b1);
    out_ready = 1'b1;
    tick();
    set_port(0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("fill_pop1_ready", in_ready[0], 1);
    chk("fill_pop1_vc", in_vcready[0], 0);
    chk("fill_pop1_flit", out_flit, 8'hD1);
    tick();
    chk("fill_pop2_ready", in_ready[0], 1);
    chk("fill_pop2_vc", in_vcready[0], 1);
    chk("fill_pop2_flit", out_flit, 8'hD2);
    tick();
    chk("fill_d3", {out_is_tail, out_flit}, {1'b1, 8'hD3});
    tick();
    chk("fill_idle", out_valid, 0);
    tick();
    chk("fill_no_extra", out_valid, 0);

    // ---------------- round-robin fairness ----------------
    do_reset();
    out_ready = 1'b1;
    for (int p = 0; p < N; p++) begin
      set_port(p, 1'b1, 8'h60 + 8'(p), 1'b1, 1'b1);
    end
    srcs.delete();
    for (int c = 0; c < 40 && srcs.size() < 5; c++) begin
      tick();
      if (out_valid) begin
        srcs.push_back(int'(out_src));
      end
    end
    in_valid = '0;
    if (srcs.size() < 5) begin
      chk("rr_timeout", srcs.size(), 5);
    end else begin
      for (int i = 0; i < 5; i++) begin
        chk("rr_src", srcs[i], i % N);
      end
    end

    // ---------------- reset mid-packet ----------------
    do_reset();
    out_ready = 1'b1;
    set_port(0, 1'b1, 8'hE1, 1'b1, 1'b0);
    tick();
    set_port(0, 1'b1, 8'hE2, 1'b0, 1'b0);
    tick();
    chk("mid_e1", out_flit, 8'hE1);
    set_port(0, 1'b1, 8'hE3, 1'b0, 1'b1);
    tick();
    set_port(0, 1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 4'hF);
    chk("mid_rst_vc", in_vcready, 4'hF);
    chk("mid_rst_flit", out_flit, 0);
    @(posedge noc_clk);
    #1;
    rst_n = 1'b1;
    set_port(0, 1'b1, 8'hF1, 1'b1, 1'b1);
    tick();
    set_port(0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("mid_new_idle", out_valid, 0);
    tick();
    chk("mid_new_flit", {out_valid, out_is_header, out_is_tail, out_flit}, {3'b111, 8'hF1});
    chk("mid_new_src", out_src, 0);
    tick();

`ifdef NOC_MERGER_PROTO_CHECK_EN
    // ---------------- stray body flit while idle ----------------
    do_reset();
    out_ready = 1'b1;
    set_port(3, 1'b1, 8'h55, 1'b0, 1'b0);
    tick();
    set_port(3, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("proto_no_fwd", out_valid && out_flit == 8'h55, 0);
    end
    chk("proto_err3", proto_err, 4'b1000);
    set_port(3, 1'b1, 8'h56, 1'b1, 1'b1);
    tick();
    set_port(3, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("proto_after", {out_valid, out_flit}, {1'b1, 8'h56});
    chk("proto_sticky", proto_err[3], 1);
    tick();
`endif

    // ---------------- randomized run against reference model ----------------
    do_reset();
    begin
      bit         busy;
      bit         busy_now;
      int         g;
      int         rr;
      logic [N-1:0] vc_exp;
      bit         push_ok [N];
      ent_t       popped;
      busy   = 1'b0;
      g      = 0;
      rr     = 0;
      vc_exp = '1;
      for (int p = 0; p < N; p++) begin
        q[p].delete();
        rem[p]     = 0;
        pend_ok[p] = 1'b0;
      end
      for (int cyc = 0; cyc < 2000; cyc++) begin
        @(negedge noc_clk);
        for (int p = 0; p < N; p++) begin
          chk("rnd_ready", in_ready[p], q[p].size() < DEPTH);
          chk("rnd_vcready", in_vcready[p], vc_exp[p]);
        end
        busy_now = busy;
        if (busy_now) begin
          chk("rnd_valid", out_valid, q[g].size() > 0);
          if (q[g].size() > 0) begin
            chk("rnd_src", out_src, g);
            chk("rnd_flit", {out_is_header, out_is_tail, out_flit}, q[g][0]);
          end
        end else begin
          chk("rnd_idle_valid", out_valid, 0);
          for (int i = 0; i < N; i++) begin
            if (!busy && q[(rr + i) % N].size() > 0) begin
              busy = 1'b1;
              g    = (rr + i) % N;
            end
          end
        end
        for (int p = 0; p < N; p++) begin
          if (!pend_ok[p]) begin
            first = (rem[p] == 0);
            if (first) begin
              rem[p] = int'($urandom_range(1, 3));
            end
            pend[p]    = '{h: first, t: (rem[p] == 1), d: 8'($urandom)};
            rem[p]     = rem[p] - 1;
            pend_ok[p] = 1'b1;
          end
          set_port(p, ($urandom % 4) != 0, pend[p].d, pend[p].h, pend[p].t);
        end
        out_ready = ($urandom % 4) != 0;
        for (int p = 0; p < N; p++) begin
          push_ok[p] = in_valid[p] && (q[p].size() < DEPTH);
        end
        if (busy_now && q[g].size() > 0 && out_ready) begin
          popped = q[g].pop_front();
          if (popped.t) begin
            busy = 1'b0;
            rr   = (g + 1) % N;
          end
        end
        for (int p = 0; p < N; p++) begin
          if (push_ok[p]) begin
            q[p].push_back(pend[p]);
            pend_ok[p] = 1'b0;
          end
          vc_exp[p] = (DEPTH - q[p].size()) >= VCT;
        end
      end
      in_valid = '0;
      chk("rnd_proto_err", proto_err, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
